// File: rtl/rf_pkg.sv
// Shared register-file definitions.
// Holds the clear-engine state encoding and the default register-file
// geometry used by regfile_sb and by the decode/hazard units that size
// their own register-address fields from the same constants.
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard for regfile_sb.
// A bit is set when an instruction with that destination issues and cleared
// when its write retires. rs_pend_o flags read ports whose source register
// still has a producer in flight.
//   clk          rising-edge clock
//   rst_i        synchronous active-high reset, clears every pending bit
//   idle_i       register file not clearing; the scoreboard only moves when high
//   clr_all_i    clear request; wipes the whole scoreboard when idle
//   we_i/wa_i    retiring write (clears pend[wa_i])
//   iss_valid_i/iss_rd_i  issuing producer (sets pend[iss_rd_i])
//   ra_i         packed read addresses, port k at [k*AW +: AW]
//   rs_pend_o    per-port hazard flags
module rf_scoreboard #(
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  idle_i,
  input  logic                  clr_all_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         wa_i,
  input  logic                  iss_valid_i,
  input  logic [AW-1:0]         iss_rd_i,
  input  logic [NREAD*AW-1:0]   ra_i,
  output logic [NREAD-1:0]      rs_pend_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (idle_i) begin
      if (clr_all_i) begin
        pend_d = '0;
      end else begin
        if (we_i && (wa_i != '0)) pend_d[wa_i] = 1'b0;
        // Applied after the retire so a new producer on the same register wins.
        if (iss_valid_i && (iss_rd_i != '0)) pend_d[iss_rd_i] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [AW-1:0] ra_k;
    logic          wr_hit;
    assign ra_k   = ra_i[k*AW +: AW];
    // A retiring write that is being forwarded resolves the hazard this cycle.
    assign wr_hit = (BYPASS != 0) && we_i && (wa_i == ra_k);
    assign rs_pend_o[k] = idle_i && (ra_k != '0) && pend_q[ra_k] && !wr_hit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass, a RAW-hazard scoreboard
// and a sequential clear engine. Register 0 reads as zero and ignores writes.
//   clk         rising-edge clock
//   Sync_reset  synchronous active-high reset (registers, scoreboard, clear FSM)
//   ra/rd       NREAD combinational read ports, packed per port
//   rs_pend     per-port "source has an in-flight producer"
//   we/wa/wd    synchronous write port (writeback)
//   iss_valid/iss_rd  issue of an instruction with a destination register
//   clr_req     start a walk that zeroes every register, one per cycle
//   clr_busy    clear walk in progress
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int AW     = $clog2(NREGS),
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    Sync_reset,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*XLEN-1:0]   rd,
  output logic [NREAD-1:0]        rs_pend,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [XLEN-1:0]         wd,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] rf_q [NREGS];
  logic            idle;

  assign idle     = (state_q == RF_IDLE);
  assign clr_busy = (state_q == RF_CLEAR);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Sync_reset) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // A write in the same cycle as clr_req commits; the walk zeroes it later.
      if (idle && we && (wa != '0)) rf_q[wa] <= wd;
      if (state_q == RF_CLEAR)      rf_q[idx_q] <= '0;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   ra_k;
    logic [XLEN-1:0] rd_k;
    assign ra_k = ra[k*AW +: AW];
    always_comb begin
      if (ra_k == '0)
        rd_k = '0;
      else if ((BYPASS != 0) && idle && we && (wa == ra_k))
        rd_k = wd;
      else
        rd_k = rf_q[ra_k];
    end
    assign rd[k*XLEN +: XLEN] = rd_k;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NREAD (NREAD),
    .BYPASS(BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_i      (Sync_reset),
    .idle_i     (idle),
    .clr_all_i  (clr_req),
    .we_i       (we),
    .wa_i       (wa),
    .iss_valid_i(iss_valid),
    .iss_rd_i   (iss_rd),
    .ra_i       (ra),
    .rs_pend_o  (rs_pend)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Three register files driven by one stimulus stream:
//   d0: 32 regs, 2 ports, XLEN 32, bypass on
//   d1: 32 regs, 2 ports, XLEN 32, bypass off
//   d2: 16 regs, 3 ports, XLEN 64, bypass on
// The driver pushes the expected combinational outputs for each cycle into a
// queue; the monitor pops and compares at the falling edge.
module tb_regfile_sb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  s_ra [3];
  logic        we;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        iss;
  logic [4:0]  iss_rd;
  logic        clr_req;

  logic [63:0]  rd_a, rd_b;
  logic [191:0] rd_c;
  logic [1:0]   rp_a, rp_b;
  logic [2:0]   rp_c;
  logic         busy_a, busy_b, busy_c;

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
    .clk(clk), .Sync_reset(rst), .ra({s_ra[1], s_ra[0]}), .rd(rd_a), .rs_pend(rp_a),
    .we(we), .wa(wa), .wd(wd[31:0]), .iss_valid(iss), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(busy_a));

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
    .clk(clk), .Sync_reset(rst), .ra({s_ra[1], s_ra[0]}), .rd(rd_b), .rs_pend(rp_b),
    .we(we), .wa(wa), .wd(wd[31:0]), .iss_valid(iss), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(busy_b));

  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(1)) dut_c (
    .clk(clk), .Sync_reset(rst), .ra({s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]}),
    .rd(rd_c), .rs_pend(rp_c),
    .we(we), .wa(wa[3:0]), .wd(wd), .iss_valid(iss), .iss_rd(iss_rd[3:0]),
    .clr_req(clr_req), .clr_busy(busy_c));

  // ---------------- reference model ----------------
  int nr[3] = '{32, 32, 16};
  int np[3] = '{2, 2, 3};
  int bp[3] = '{1, 0, 1};
  int xw[3] = '{32, 32, 64};

  logic [63:0] m_reg  [3][32];
  bit          m_pend [3][32];
  int          m_left [3];     // clear cycles still to run (0 = idle)
  int          m_cidx [3];     // next register the clear walk zeroes
  bit          m_valid = 1'b0;

  typedef struct packed {
    logic [2:0][2:0][63:0] rd;
    logic [2:0][2:0]       pend;
    logic [2:0]            busy;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [63:0] dmask(int d);
    return (xw[d] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      bit idle;
      int w;
      idle = (m_left[d] == 0);
      w    = int'(wa) % nr[d];
      e.busy[d] = !idle;
      for (int k = 0; k < np[d]; k++) begin
        int a;
        bit fwd;
        a   = int'(s_ra[k]) % nr[d];
        fwd = (bp[d] == 1) && idle && we && (w == a);
        if (a == 0) begin
          e.rd[d][k]   = '0;
          e.pend[d][k] = 1'b0;
        end else begin
          e.rd[d][k]   = fwd ? (wd & dmask(d)) : m_reg[d][a];
          e.pend[d][k] = idle && m_pend[d][a] && !fwd;
        end
      end
    end
    return e;
  endfunction

  function automatic void model_edge();
    for (int d = 0; d < 3; d++) begin
      int w, ir;
      w  = int'(wa) % nr[d];
      ir = int'(iss_rd) % nr[d];
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_reg[d][r]  = '0;
          m_pend[d][r] = 1'b0;
        end
        m_left[d] = 0;
        m_cidx[d] = 0;
      end else if (m_left[d] == 0) begin
        if (we && w != 0) m_reg[d][w] = wd & dmask(d);
        if (clr_req) begin
          for (int r = 0; r < 32; r++) m_pend[d][r] = 1'b0;
          m_left[d] = nr[d];
          m_cidx[d] = 0;
        end else begin
          if (we && w != 0) m_pend[d][w] = 1'b0;
          if (iss && ir != 0) m_pend[d][ir] = 1'b1;
        end
      end else begin
        m_reg[d][m_cidx[d]] = '0;
        m_cidx[d]++;
        m_left[d]--;
      end
    end
    if (rst) m_valid = 1'b1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] act_rd(int d, int k);
    case (d)
      0:       return {32'h0, rd_a[k*32 +: 32]};
      1:       return {32'h0, rd_b[k*32 +: 32]};
      default: return rd_c[k*64 +: 64];
    endcase
  endfunction

  function automatic logic act_pend(int d, int k);
    case (d)
      0:       return rp_a[k];
      1:       return rp_b[k];
      default: return rp_c[k];
    endcase
  endfunction

  function automatic logic act_busy(int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d_busy", d), 64'(act_busy(d)), 64'(e.busy[d]));
        for (int k = 0; k < np[d]; k++) begin
          check($sformatf("d%0d_rd%0d", d, k), act_rd(d, k), e.rd[d][k]);
          check($sformatf("d%0d_pend%0d", d, k), 64'(act_pend(d, k)), 64'(e.pend[d][k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    rst = 1'b0; we = 1'b0; wa = '0; wd = '0; iss = 1'b0; iss_rd = '0; clr_req = 1'b0;
    for (int k = 0; k < 3; k++) s_ra[k] = '0;
  endtask

  task automatic step();
    if (m_valid) expq.push_back(expect_now());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  int cnt_a, cnt_c;

  initial begin
    idle_in();
    rst = 1'b1; step(); step();

    // write/read, write to x0
    idle_in(); we = 1'b1; wa = 5'd5; wd = 64'hDEADBEEF; step();
    idle_in(); s_ra[0] = 5'd5; step();
    idle_in(); we = 1'b1; wa = 5'd0; wd = 64'h1234; step();
    idle_in(); s_ra[0] = 5'd0; s_ra[1] = 5'd5; step();

    // same-cycle bypass
    idle_in(); we = 1'b1; wa = 5'd7; wd = 64'h5A5A_5A5A_A5A5_A5A5; s_ra[1] = 5'd7; step();
    idle_in(); s_ra[1] = 5'd7; step();

    // scoreboard
    idle_in(); iss = 1'b1; iss_rd = 5'd9; step();
    idle_in(); s_ra[0] = 5'd9; step();
    idle_in(); s_ra[0] = 5'd9; we = 1'b1; wa = 5'd9; wd = 64'h99; step();
    idle_in(); s_ra[0] = 5'd9; step();
    idle_in(); iss = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 64'h9A; step();
    idle_in(); s_ra[0] = 5'd9; s_ra[2] = 5'd9; step();

    // load x1..x31, then clear with a second request mid-walk
    for (int i = 1; i < 32; i++) begin
      idle_in(); we = 1'b1; wa = 5'(i);
      wd = {8'(i), 24'hABCDEF, 8'(i), 24'h123456};
      iss = (i % 3 == 0); iss_rd = 5'(i);
      step();
    end
    idle_in(); s_ra[0] = 5'd3; s_ra[1] = 5'd15; s_ra[2] = 5'd0; step();
    cnt_a = 0; cnt_c = 0;
    idle_in(); clr_req = 1'b1; we = 1'b1; wa = 5'd4; wd = 64'hFEED; step();
    if (busy_a) cnt_a++;
    if (busy_c) cnt_c++;
    for (int i = 0; i < 39; i++) begin
      idle_in();
      clr_req = (i == 5);
      we = 1'b1; wa = pick(); wd = {$urandom, $urandom};
      iss = 1'b1; iss_rd = pick();
      s_ra[0] = pick(); s_ra[1] = pick(); s_ra[2] = pick();
      step();
      if (busy_a) cnt_a++;
      if (busy_c) cnt_c++;
    end
    check("clr_len_32", 64'(cnt_a), 64'd32);
    check("clr_len_16", 64'(cnt_c), 64'd16);
    for (int i = 0; i < 32; i++) begin
      idle_in(); s_ra[0] = 5'(i); s_ra[1] = 5'(31 - i); s_ra[2] = 5'(i); step();
    end

    // reset in the tenth clear cycle
    idle_in(); we = 1'b1; wa = 5'd12; wd = 64'h1212; step();
    idle_in(); clr_req = 1'b1; step();
    for (int i = 0; i < 9; i++) begin idle_in(); step(); end
    idle_in(); rst = 1'b1; step();
    check("rst_abort_busy", 64'(busy_a), 64'd0);
    idle_in(); we = 1'b1; wa = 5'd12; wd = 64'h0BAD_F00D; s_ra[0] = 5'd12; step();
    idle_in(); s_ra[0] = 5'd12; s_ra[1] = 5'd1; step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idle_in();
      rst     = ($urandom_range(0, 99) == 0);
      clr_req = ($urandom_range(0, 59) == 0);
      we      = 1'($urandom_range(0, 1));
      wa      = pick();
      wd      = {$urandom, $urandom};
      iss     = ($urandom_range(0, 9) < 4);
      iss_rd  = pick();
      for (int k = 0; k < 3; k++) s_ra[k] = pick();
      step();
    end

    idle_in();
    @(negedge clk);
    #1;
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core integer register file.
- Provides NREAD asynchronous read ports with write-to-read bypass, one synchronous write port, and a hardwired-zero register 0.
- Adds a per-register pending scoreboard, so the pipeline can stall on unresolved RAW hazards.
- Adds a software-requested sequential clear engine.
- Sits between decode (reads, issue) and writeback (write) in the RISC-V pipeline.

Parameters:
- XLEN, 32: data width of each register.
- NREGS, 32: number of registers; power of two, at least 2.
- AW, $clog2(NREGS): address width (derived; not overridden).
- NREAD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = array contents only.

Ports:
- clk  in  1  rising-edge clock.
- Sync_reset  in  1  synchronous, active-high reset.
- ra  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd  out  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rs_pend  out  NREAD  port k source has an in-flight producer.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- iss_valid  in  1  instruction issued with a destination register.
- iss_rd  in  AW  destination register of the issued instruction.
- clr_req  in  1  start a sequential clear of all registers and the scoreboard.
- clr_busy  out  1  clear engine active.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (Sync_reset), sampled on the rising edge.
- Reset (Sync_reset=1 at the edge):
  - All NREGS registers become 0.
  - All pending bits become 0.
  - FSM goes to IDLE; clear index goes to 0.
  - clr_busy=0.
  - rd and rs_pend are combinational; after reset, rd=0 and rs_pend=0.
  - Reset asserted mid-clear aborts the clear; the end state is identical to a completed clear.
- Read (combinational, zero latency):
  - ra=0 always returns rd=0 and rs_pend=0.
  - Otherwise, if BYPASS=1, FSM=IDLE, we=1 and wa==ra, then rd=wd.
  - Otherwise rd=reg[ra].
- Write:
  - At the rising edge, if FSM=IDLE, we=1 and wa!=0, then reg[wa]<=wd.
  - Writes to address 0 are dropped.
- Scoreboard pend[NREGS], updated at the edge, only in IDLE:
  - Clear condition: we=1 and wa!=0 clears pend[wa].
  - Set condition: iss_valid=1 and iss_rd!=0 sets pend[iss_rd].
  - If the clear and the set hit the same register, set wins (a new producer is in flight).
  - rs_pend[k] = pend[ra_k] AND NOT(we AND wa==ra_k AND BYPASS=1 AND FSM=IDLE). A retiring write with bypass removes the hazard in the same cycle.
  - With BYPASS=0 the stall lasts one extra cycle.
- Clear FSM:
  - IDLE → CLEAR when clr_req=1. At that edge, idx<=0 and all pend bits are cleared.
  - CLEAR: each edge does reg[idx]<=0 and idx<=idx+1.
  - When idx==NREGS-1, CLEAR → IDLE after that edge's clear.
  - clr_busy = (FSM==CLEAR): high for exactly NREGS cycles, starting the cycle after clr_req is sampled.
  - In CLEAR:
    - we and iss_valid are ignored.
    - Bypass is disabled.
    - Reads return current array contents, which may be partially cleared.
    - rs_pend is forced to 0.
  - clr_req while in CLEAR is ignored; it neither restarts nor extends the clear.
  - clr_req and we in the same IDLE cycle: the write commits and is then cleared by the walk.
- Width rules:
  - idx is AW bits wide, and the terminal test uses an explicit compare against NREGS-1.
  - No arithmetic on data.

Decomposition:
- Shared package rf_pkg holds:
  - FSM state enum (RF_IDLE, RF_CLEAR).
  - Default XLEN and NREGS constants, shared with the decode and hazard units.
- One natural sub-module: rf_scoreboard, which holds:
  - the pend array and its set/clear priority;
  - the per-port rs_pend mask logic.
- The array, bypass muxes and clear FSM stay in regfile_sb.

Test Plan:
1. Reset, then write 0xDEADBEEF to x5, then read x5 on port 0 the next cycle → rd0=0xDEADBEEF. Write 0x1234 to x0 → reading x0 gives 0.
2. Same-cycle bypass: we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle → rd1=0xA5A5A5A5 before the edge. With BYPASS=0 → old value, 0.
3. Scoreboard:
   - iss_rd=9, then ra0=9 → rs_pend0=1.
   - In a later cycle, we=1 with wa=9 → rs_pend0=0 in that cycle. The cycle after → pend cleared.
   - Simultaneous iss_rd=9 and wa=9 → pend[9] remains 1.
4. Clear:
   - Load x1..x31 with distinct values, then pulse clr_req.
   - Required: clr_busy high for exactly 32 cycles; we and iss_valid during CLEAR have no effect; afterwards all registers and pend read 0.
   - A second clr_req mid-clear does not extend clr_busy.
5. Reset mid-clear: Sync_reset at CLEAR cycle 10 → next cycle clr_busy=0, all registers 0, and a normal write succeeds the cycle after.
6. Parametric: NREGS=16, NREAD=3, XLEN=64.
   - Port-independent reads of x3, x15, x0 give their respective values and 0.
   - The clear lasts exactly 16 cycles.
